apb_cfg_sequencer: RTL
======================

Name: apb_cfg_sequencer

Overview:
- Table-driven APB3 master that configures fabric/MSS peripherals through the FIC_2 APB master path once the MSS reports ready.
- Walks an external configuration table of WRITE / POLL / END entries, issues the APB transfers, and enforces timeouts.
- Raises CONFIG_DONE or ERROR; CONFIG_DONE feeds CoreResetP CONFIG1_DONE/CONFIG2_DONE in place of today's tie-high.

Parameters:
- NUM_ENTRIES, 16, table depth; index width IDX_W = clog2(NUM_ENTRIES).
- ADDR_W, 16, PADDR width.
- DATA_W, 32, PWDATA/PRDATA width.
- PREADY_TMO, 255, max ACCESS cycles waiting for PREADY before error.
- POLL_MAX, 1023, max POLL re-reads before error.

Ports:
- CLK_BASE  in  1  fabric clock (CCC GL0).
- RESET_N  in  1  asynchronous active-low reset.
- START  in  1  level; sequence begins on first cycle high while IDLE (driven by MSS_READY).
- TBL_IDX  out  IDX_W  current table index to external ROM.
- TBL_OP  in  2  entry op: 0=WRITE, 1=POLL, 2=END, 3=reserved (treated as error).
- TBL_ADDR  in  ADDR_W  entry address.
- TBL_DATA  in  DATA_W  write data / poll expected value.
- TBL_MASK  in  DATA_W  poll compare mask.
- PSEL, PENABLE, PWRITE  out  1 each  APB master controls.
- PADDR  out  ADDR_W;  PWDATA  out  DATA_W.
- PREADY, PSLVERR  in  1 each;  PRDATA  in  DATA_W.
- CONFIG_DONE  out  1  sticky; table reached END cleanly.
- ERROR  out  1  sticky; sequence aborted.
- ERR_IDX  out  IDX_W  index of the failing entry.
- ERR_CODE  out  2  1=PSLVERR, 2=PREADY timeout, 3=poll exhausted or bad op.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- FSM states: IDLE, FETCH, SETUP, ACCESS, CHECK, DONE, FAIL.
- IDLE -> FETCH when START=1. TBL_IDX=0.
- FETCH (1 cycle): register the entry, which is combinational from TBL_IDX.
  - END -> DONE.
  - op 3 -> FAIL with code 3.
  - Else -> SETUP.
- SETUP: PSEL=1, PENABLE=0, PADDR=TBL_ADDR, PWRITE=(op==WRITE), PWDATA=TBL_DATA (0 for POLL). Next cycle -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1, with PADDR/PWRITE/PWDATA held stable.
  - Wait-cycle counter increments each cycle PREADY=0; if it reaches PREADY_TMO -> FAIL code 2, drop PSEL/PENABLE.
  - On PREADY=1: capture PRDATA and PSLVERR, deassert PSEL/PENABLE, go to CHECK. Minimum transfer is 2 cycles.
- CHECK:
  - PSLVERR -> FAIL code 1.
  - WRITE -> TBL_IDX+1, FETCH.
  - POLL with (PRDATA & MASK)==(DATA & MASK) -> TBL_IDX+1, FETCH, poll counter cleared.
  - POLL mismatch: poll counter+1; if it hits POLL_MAX -> FAIL code 3, else back to SETUP on the same entry.
- Index wrap: TBL_IDX reaching NUM_ENTRIES-1 without END -> after that entry completes, FAIL code 3 with ERR_IDX=NUM_ENTRIES-1. No wrap to 0.
- DONE: CONFIG_DONE=1, bus idle; holds until reset. START is ignored.
- FAIL: ERROR=1, ERR_IDX/ERR_CODE latched; holds until reset. CONFIG_DONE stays 0.
- START deasserting mid-sequence has no effect. Only RESET_N aborts.
- Reset mid-transfer: PSEL/PENABLE drop immediately (asynchronous); the sequence restarts from index 0 after the next START.
- PREADY and PSLVERR are sampled only in ACCESS.
- Latency: a WRITE entry with PREADY=1 takes 4 cycles (FETCH, SETUP, ACCESS, CHECK).

Optional Feature:
- Macro APB_CFG_READBACK_EN.
- Defined: each successful WRITE is followed by an APB read of the same address (extra SETUP/ACCESS). Compare (PRDATA & TBL_MASK) against (TBL_DATA & TBL_MASK); mismatch -> FAIL code 3. The readback read uses the same PREADY timeout and PSLVERR handling.
- Undefined: no readback; TBL_MASK is used only by POLL.

Decomposition:
- Package apb_cfg_pkg:
  - Op encoding constants (OP_WRITE, OP_POLL, OP_END).
  - ERR_CODE constants.
  - FSM state typedef.
- Sub-module apb_cfg_timer: loadable down-counter with an expiry flag. It is instantiated twice, once for the PREADY timeout and once for the poll count.

Test Plan:
- Table {WRITE 0x0010<-0xA5A5_0001, WRITE 0x0014<-0x3, END}, PREADY=1 -> two APB writes with exact PADDR/PWDATA; CONFIG_DONE=1 at cycle 9 after START; ERROR=0.
- POLL 0x0020 mask 0x1 expect 0x1; PRDATA=0 for 3 reads, then 1 -> 4 reads issued, then advance; CONFIG_DONE=1.
- PREADY stuck 0 on entry 2, PREADY_TMO=4 -> PSEL drops after 4 wait cycles; ERROR=1, ERR_IDX=2, ERR_CODE=2.
- PSLVERR=1 on entry 0 write -> ERROR=1, ERR_CODE=1, ERR_IDX=0; no further transfers.
- RESET_N low during ACCESS of entry 1 -> PSEL/PENABLE 0 immediately. Re-START -> writes restart at index 0.
- With APB_CFG_READBACK_EN: write 0x5, readback returns 0x4 with mask 0xF -> ERROR=1, ERR_CODE=3; readback returning 0x5 -> proceeds.

Source files
------------

// File: rtl/apb_cfg_pkg.sv
// Shared encodings for the table-driven APB configuration sequencer.
// Entry op codes, error codes and FSM state type.
package apb_cfg_pkg;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_POLL  = 2'd1;
  localparam logic [1:0] OP_END   = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_SLVERR = 2'd1;
  localparam logic [1:0] ERR_TMO    = 2'd2;
  localparam logic [1:0] ERR_SEQ    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETUP,
    ST_ACCESS,
    ST_CHECK,
    ST_DONE,
    ST_FAIL
  } state_t;

endpackage

// File: rtl/apb_cfg_timer.sv
// Loadable down-counter; expired_o flags the decrement that would take it past 1.
// Used for both the PREADY wait budget and the POLL retry budget.
module apb_cfg_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = dec_i && (cnt_q <= W'(1));

endmodule

// File: rtl/apb_cfg_sequencer.sv
// Table-driven APB3 master: walks WRITE/POLL/END entries and raises CONFIG_DONE or ERROR.
// Optional post-write readback compare is enabled by defining APB_CFG_READBACK_EN.
//
//   state     | meaning
//   ST_IDLE   | waiting for START
//   ST_FETCH  | latch table entry at TBL_IDX, decode op
//   ST_SETUP  | APB setup phase (PSEL=1, PENABLE=0)
//   ST_ACCESS | APB access phase, waiting for PREADY
//   ST_CHECK  | evaluate response, advance / retry / abort
//   ST_DONE   | table finished, CONFIG_DONE held until reset
//   ST_FAIL   | aborted, ERROR/ERR_IDX/ERR_CODE held until reset
module apb_cfg_sequencer
  import apb_cfg_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int PREADY_TMO  = 255,
  parameter int POLL_MAX    = 1023,
  localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
  input  logic              CLK_BASE,
  input  logic              RESET_N,
  input  logic              START,
  output logic [IDX_W-1:0]  TBL_IDX,
  input  logic [1:0]        TBL_OP,
  input  logic [ADDR_W-1:0] TBL_ADDR,
  input  logic [DATA_W-1:0] TBL_DATA,
  input  logic [DATA_W-1:0] TBL_MASK,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  input  logic [DATA_W-1:0] PRDATA,
  output logic              CONFIG_DONE,
  output logic              ERROR,
  output logic [IDX_W-1:0]  ERR_IDX,
  output logic [1:0]        ERR_CODE
);

  localparam int TMO_W  = $clog2(PREADY_TMO + 1);
  localparam int POLL_W = $clog2(POLL_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] rdata_q;
  logic              slverr_q;
  logic              rb_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              done_q;
  logic              err_q;
  logic [IDX_W-1:0]  err_idx_q;
  logic [1:0]        err_code_q;

  logic rd_match;
  logic pr_load;
  logic pr_dec;
  logic pr_expired;
  logic poll_load;
  logic poll_dec;
  logic poll_expired;

  assign rd_match = ((rdata_q ^ data_q) & mask_q) == '0;

  // PREADY budget restarts for every transfer, including poll re-reads and readbacks.
  assign pr_load = (state_q == ST_SETUP);
  assign pr_dec  = (state_q == ST_ACCESS) && !PREADY;

  // Poll budget restarts per entry, so a matching poll implicitly clears it.
  assign poll_load = (state_q == ST_FETCH);
  assign poll_dec  = (state_q == ST_CHECK) && !slverr_q && (op_q == OP_POLL) && !rd_match;

  apb_cfg_timer #(.W(TMO_W)) u_pready_timer (
    .clk_i      (CLK_BASE),
    .rst_n_i    (RESET_N),
    .load_i     (pr_load),
    .load_val_i (TMO_W'(PREADY_TMO)),
    .dec_i      (pr_dec),
    .expired_o  (pr_expired)
  );

  apb_cfg_timer #(.W(POLL_W)) u_poll_timer (
    .clk_i      (CLK_BASE),
    .rst_n_i    (RESET_N),
    .load_i     (poll_load),
    .load_val_i (POLL_W'(POLL_MAX)),
    .dec_i      (poll_dec),
    .expired_o  (poll_expired)
  );

  always_ff @(posedge CLK_BASE or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      op_q       <= OP_WRITE;
      data_q     <= '0;
      mask_q     <= '0;
      rdata_q    <= '0;
      slverr_q   <= 1'b0;
      rb_q       <= 1'b0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            idx_q   <= '0;
            state_q <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          op_q   <= TBL_OP;
          data_q <= TBL_DATA;
          mask_q <= TBL_MASK;
          rb_q   <= 1'b0;
          if (TBL_OP == OP_END) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (TBL_OP == OP_RSVD) begin
            err_q      <= 1'b1;
            err_idx_q  <= idx_q;
            err_code_q <= ERR_SEQ;
            state_q    <= ST_FAIL;
          end else begin
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            paddr_q   <= TBL_ADDR;
            pwrite_q  <= (TBL_OP == OP_WRITE);
            pwdata_q  <= (TBL_OP == OP_WRITE) ? TBL_DATA : '0;
            state_q   <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (PREADY) begin
            rdata_q   <= PRDATA;
            slverr_q  <= PSLVERR;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= ST_CHECK;
          end else if (pr_expired) begin
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            err_q      <= 1'b1;
            err_idx_q  <= idx_q;
            err_code_q <= ERR_TMO;
            state_q    <= ST_FAIL;
          end
        end

        ST_CHECK: begin
          if (slverr_q) begin
            err_q      <= 1'b1;
            err_idx_q  <= idx_q;
            err_code_q <= ERR_SLVERR;
            state_q    <= ST_FAIL;
          end else if ((op_q == OP_WRITE) && !rb_q) begin
`ifdef APB_CFG_READBACK_EN
            rb_q      <= 1'b1;
            psel_q    <= 1'b1;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            state_q   <= ST_SETUP;
`else
            if (idx_q == LAST_IDX) begin
              err_q      <= 1'b1;
              err_idx_q  <= idx_q;
              err_code_q <= ERR_SEQ;
              state_q    <= ST_FAIL;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= ST_FETCH;
            end
`endif
          end else if (rd_match) begin
            // No wrap: running off the last entry without END is an error.
            if (idx_q == LAST_IDX) begin
              err_q      <= 1'b1;
              err_idx_q  <= idx_q;
              err_code_q <= ERR_SEQ;
              state_q    <= ST_FAIL;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= ST_FETCH;
            end
          end else if (rb_q || poll_expired) begin
            err_q      <= 1'b1;
            err_idx_q  <= idx_q;
            err_code_q <= ERR_SEQ;
            state_q    <= ST_FAIL;
          end else begin
            psel_q  <= 1'b1;
            state_q <= ST_SETUP;
          end
        end

        ST_DONE: begin
        end

        ST_FAIL: begin
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign TBL_IDX     = idx_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign CONFIG_DONE = done_q;
  assign ERROR       = err_q;
  assign ERR_IDX     = err_idx_q;
  assign ERR_CODE    = err_code_q;

endmodule
